// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the byte-addressable M-stage data memory.
package dm_pkg;

    // Access size encodings carried on DMB_size_M_i.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    // Sequencer states: normal operation or clear sweep in progress.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dm_state_e;

    // Lanes touched by an access of the given size at the given byte offset.
    // Halfwords only look at offset bit 1; misalignment is flagged elsewhere.
    function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << off;
            SZ_H:    mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load path: pick the addressed byte/halfword out of a memory word,
// right-align it and zero- or sign-extend it to 32 bits.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [31:0] w_sh_b;
    logic [31:0] w_sh_h;

    // Byte lanes shift by 8*offset, halfword lanes by 16*offset[1].
    assign w_sh_b = i_word >> {i_off, 3'b000};
    assign w_sh_h = i_word >> {i_off[1], 4'b0000};

    // Extend the selected lane; word loads pass through and ignore i_sext.
    always_comb begin
        o_data = '0;
        case (i_size)
            SZ_B:    o_data = {{24{i_sext & w_sh_b[7]}}, w_sh_b[7:0]};
            SZ_H:    o_data = {{16{i_sext & w_sh_h[15]}}, w_sh_h[15:0]};
            SZ_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/dm_bytewise.sv
// Byte-addressable data memory for the M stage: lane-merged stores,
// extended loads, address error detection, a clear sweep sequencer that
// holds busy while it wipes the array, and a registered store trace port.
module dm_bytewise
    import dm_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int CLR_ON_RESET = 1
)
(
    input  logic        DMB_clk_M_i,
    input  logic        DMB_ret_M_i,
    input  logic [31:0] DMB_npc_M_i,
    input  logic [31:0] DMB_alo_M_i,
    input  logic [31:0] DMB_wtd_M_i,
    input  logic        DMB_we_M_i,
    input  logic        DMB_re_M_i,
    input  logic [1:0]  DMB_size_M_i,
    input  logic        DMB_sext_M_i,
    input  logic        DMB_clr_M_i,
    output logic [31:0] DMB_dmd_M_o,
    output logic        DMB_busy_M_o,
    output logic        DMB_aerr_M_o,
    output logic        DMB_trv_M_o,
    output logic [31:0] DMB_tra_M_o,
    output logic [31:0] DMB_trd_M_o,
    output logic [31:0] DMB_trpc_M_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam dm_state_e RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [31:0]       r_mem [DEPTH];
    dm_state_e         r_state;
    dm_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;

    logic              r_trv;
    logic [31:0]       r_tra;
    logic [31:0]       r_trd;
    logic [31:0]       r_trpc;

    logic              w_busy;
    logic              w_clr_we;
    logic              w_ptr_last;
    logic              w_req;
    logic              w_misal;
    logic              w_oor;
    logic              w_aerr;
    logic              w_st_acc;
    logic [ADDR_W-1:0] w_widx;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wd_al;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_ld_ext;

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    assign w_widx  = DMB_alo_M_i[ADDR_W+1:2];
    assign w_off   = DMB_alo_M_i[1:0];
    assign w_req   = DMB_we_M_i | DMB_re_M_i;
    assign w_misal = (DMB_size_M_i == SZ_R)
                   | ((DMB_size_M_i == SZ_H) & DMB_alo_M_i[0])
                   | ((DMB_size_M_i == SZ_W) & (|DMB_alo_M_i[1:0]));
    assign w_oor   = |DMB_alo_M_i[31:ADDR_W+2];
    // Errors are masked during the sweep since the request is ignored anyway.
    assign w_aerr  = w_req & (w_misal | w_oor) & ~w_busy;

    // A store is taken only in IDLE, error-free and not racing a clear.
    assign w_st_acc = (r_state == ST_IDLE) & DMB_we_M_i & ~w_aerr & ~DMB_clr_M_i;

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    assign w_ptr_last = (r_ptr == {ADDR_W{1'b1}});

    // State register; reset (re)starts the sweep when clear-on-reset is set.
    always_ff @(posedge DMB_clk_M_i or posedge DMB_ret_M_i) begin
        if (DMB_ret_M_i) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a clear request starts the sweep, the last word ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (DMB_clr_M_i) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_ptr_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State outputs: busy and the sweep write enable both mirror CLEAR.
    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
        end
    end

    // Sweep pointer; it wraps back to 0 after the last word.
    always_ff @(posedge DMB_clk_M_i or posedge DMB_ret_M_i) begin
        if (DMB_ret_M_i) begin
            r_ptr <= '0;
        end else if (w_clr_we) begin
            r_ptr <= r_ptr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Store merge and array
    // ------------------------------------------------------------------
    assign w_be      = be_mask(DMB_size_M_i, w_off);
    assign w_rd_word = r_mem[w_widx];

    // Replicate store data so every candidate lane sees the right bits.
    always_comb begin
        w_wd_al = DMB_wtd_M_i;
        case (DMB_size_M_i)
            SZ_B:    w_wd_al = {4{DMB_wtd_M_i[7:0]}};
            SZ_H:    w_wd_al = {2{DMB_wtd_M_i[15:0]}};
            default: w_wd_al = DMB_wtd_M_i;
        endcase
    end

    // Merge: enabled lanes take new data, the rest keep the stored bytes.
    always_comb begin
        w_merged = w_rd_word;
        for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
                w_merged[8*k +: 8] = w_wd_al[8*k +: 8];
            end
        end
    end

    // Array write port: the sweep has priority, stores are whole merged words.
    always_ff @(posedge DMB_clk_M_i) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_st_acc) begin
            r_mem[w_widx] <= w_merged;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    dm_lane_ext u_lane_ext (
        .i_word (w_rd_word),
        .i_off  (w_off),
        .i_size (DMB_size_M_i),
        .i_sext (DMB_sext_M_i),
        .o_data (w_ld_ext)
    );

    assign DMB_dmd_M_o  = (DMB_re_M_i & ~w_aerr & ~w_busy) ? w_ld_ext : 32'h0;
    assign DMB_busy_M_o = w_busy;
    assign DMB_aerr_M_o = w_aerr;

    // ------------------------------------------------------------------
    // Trace port
    // ------------------------------------------------------------------
    // One-cycle valid per accepted store; payload holds between stores.
    always_ff @(posedge DMB_clk_M_i or posedge DMB_ret_M_i) begin
        if (DMB_ret_M_i) begin
            r_trv  <= 1'b0;
            r_tra  <= '0;
            r_trd  <= '0;
            r_trpc <= '0;
        end else begin
            r_trv <= w_st_acc;
            if (w_st_acc) begin
                r_tra  <= {DMB_alo_M_i[31:2], 2'b00};
                r_trd  <= w_merged;
                r_trpc <= DMB_npc_M_i;
            end
        end
    end

    assign DMB_trv_M_o  = r_trv;
    assign DMB_tra_M_o  = r_tra;
    assign DMB_trd_M_o  = r_trd;
    assign DMB_trpc_M_o = r_trpc;

endmodule

// File: doc/dm_bytewise.md
Name: dm_bytewise

Overview:
Parametrised, byte-addressable data memory for the M stage of the pipeline. It supports byte, halfword and word stores with per-lane merge, and loads with zero/sign extension. It detects misaligned and out-of-range accesses. A multi-cycle clear sequencer wipes the array after reset or on request, and asserts a busy flag so the pipeline stalls during the wipe. A registered write-trace port replaces simulation-only logging.

Parameters:
ADDR_W, 10, word-address bits; DEPTH = 2**ADDR_W words of 32 bits
CLR_ON_RESET, 1, 1 = sweep-clear the array after reset; 0 = array contents are undefined after reset

Ports:
DMB_clk_M_i  in  1  clock; all state updates on the rising edge
DMB_ret_M_i  in  1  reset; asynchronous, active-high
DMB_npc_M_i  in  32  PC of the M-stage instruction (trace only)
DMB_alo_M_i  in  32  byte address (ALU output)
DMB_wtd_M_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
DMB_we_M_i  in  1  store request
DMB_re_M_i  in  1  load request
DMB_size_M_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
DMB_sext_M_i  in  1  load extension: 1 sign-extend, 0 zero-extend
DMB_clr_M_i  in  1  soft clear request (single-cycle pulse)
DMB_dmd_M_o  out  32  load data, right-aligned and extended
DMB_busy_M_o  out  1  clear sweep in progress
DMB_aerr_M_o  out  1  address error for the current request
DMB_trv_M_o  out  1  trace valid (one cycle)
DMB_tra_M_o  out  32  trace word address
DMB_trd_M_o  out  32  trace: full merged word written
DMB_trpc_M_o  out  32  trace PC

Behaviour:
- Reset and clock: single clock DMB_clk_M_i. Reset DMB_ret_M_i is asynchronous and active-high.
- On reset:
  - state <= CLEAR if CLR_ON_RESET, else IDLE
  - clear pointer <= 0
  - trv, tra, trd, trpc <= 0
  - busy reflects the new state immediately (combinational from state)
- Endianness: little-endian lanes; byte offset k maps to bits [8k+7:8k]. Word index = alo[ADDR_W+1:2].
- Address error: aerr = (we|re) & (size==11 | (size==01 & alo[0]) | (size==10 & alo[1:0]!=0) | alo[31:ADDR_W+2]!=0). aerr is combinational and forced to 0 while busy.
- Store (IDLE, we=1, aerr=0, clr=0): on the clock edge, only the lanes selected by the access are written.
  - byte: lane alo[1:0] <= wtd[7:0]
  - half: lanes {alo[1],0} and {alo[1],1} <= wtd[15:0]
  - word: all lanes <= wtd
  - Unselected lanes keep their value.
- Load: combinational from the array.
  - Lane select by alo[1:0] and size, then zero- or sign-extend per sext.
  - Word loads ignore sext.
  - dmd = 0 when re=0, aerr=1 or busy=1.
  - A load in the same cycle as a store to the same word returns the old word; the new data is visible from the next cycle.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr=1. Any store in that cycle is dropped.
  - In CLEAR, each cycle: mem[ptr] <= 0, ptr++.
  - When ptr==DEPTH-1, that word is written and the FSM moves to IDLE on the next edge. The sweep takes exactly DEPTH cycles.
  - In CLEAR, we, re and clr are ignored; stores are dropped, not queued.
  - Asserting reset mid-sweep restarts the sweep at ptr 0.
- Trace: registered, one cycle after an accepted store.
  - trv=1, tra={alo[31:2],2'b00}, trd = merged 32-bit word, trpc = npc.
  - trv=0 on every other cycle. tra, trd and trpc hold their last values.
- Errored or dropped stores produce no trace and leave memory unchanged.

Decomposition:
- Package dm_pkg:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - FSM state encoding ST_IDLE, ST_CLEAR
  - byte-enable function size/offset -> 4-bit mask
- Sub-module dm_lane_ext: combinational lane select and extend for loads (word, offset, size, sext -> 32-bit result).
- Store merge and the FSM stay in the top module.

Test Plan:
- Reset sweep (ADDR_W=10): pulse reset after writing nonzero data at word 5 -> busy=1 for exactly 1024 cycles, then 0; lw 0x14 -> 0x00000000.
- Byte merge: sw 0x10 0xAABBCCDD, then sb 0x11 0x000000EE -> lw 0x10 = 0xAABBEEDD; lb 0x11 = 0xFFFFFFEE; lbu 0x11 = 0x000000EE.
- Halfword: sh 0x12 0x00008001 -> lw 0x10 = 0x8001EEDD; lh 0x12 = 0xFFFF8001; lhu 0x12 = 0x00008001.
- Errors:
  - sh 0x13 -> aerr=1, memory unchanged, trv stays 0
  - sw 0x1000 (ADDR_W=10) -> aerr=1
  - lw 0x02 -> aerr=1, dmd=0
- Soft clear: clr=1 with sw 0x20 0x12345678 in the same cycle -> store dropped; busy for 1024 cycles; reset asserted at sweep cycle 300 -> sweep restarts at 0 and lasts the full 1024 cycles.
- Trace: sw 0x24 0xCAFEF00D with npc 0x00003004 -> next cycle trv=1, tra=0x24, trd=0xCAFEF00D, trpc=0x00003004; following cycle trv=0.
